// File: rtl/spi_command_decoder_pkg.sv
// Shared definitions for the SPI command decoder: FSM encoding, command byte
// layout and the idle levels of the synchronised SPI-side inputs.
package spi_command_decoder_pkg;

  localparam int unsigned DATA_W             = 8;
  localparam int unsigned READ_FLAG_BIT      = 7;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 7;

  // Levels the synchronisers hold while the SPI bus is quiet.
  localparam logic CS_IDLE = 1'b1;
  localparam logic TC_IDLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_e;

endpackage

// File: rtl/spi_command_decoder_sync_edge_detector.sv
// Multi-flop synchroniser with a history flop; emits the synced level and
// single-cycle registered rise/fall events.
module sync_edge_detector #(
  parameter int unsigned SyncStages = 2,
  parameter logic        IdleLevel  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  hist_q;
  logic                  rise_q;
  logic                  fall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SyncStages{IdleLevel}};
      hist_q <= IdleLevel;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], d_i};
      hist_q <= sync_q[SyncStages-1];
      rise_q <= sync_q[SyncStages-1] & ~hist_q;
      fall_q <= ~sync_q[SyncStages-1] & hist_q;
    end
  end

  assign level_o = sync_q[SyncStages-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_command_decoder.sv
// Decodes SPI command/data bytes into register-bank write strobes and
// read-back data with auto-incrementing, wrapping addresses.
module spi_command_decoder
  import spi_command_decoder_pkg::*;
#(
  parameter int unsigned SyncStages = 2,
  parameter int unsigned AddrWidth  = DEFAULT_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n_i,
  input  logic              transfer_complete_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic [DATA_W-1:0] read_data_i,
  output logic [DATA_W-1:0] address_bus_o,
  output logic [DATA_W-1:0] data_out_o,
  output logic              write_n_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              busy_o
);

  logic cs_level, cs_rise, cs_fall;
  logic tc_level, byte_evt, tc_fall;

  sync_edge_detector #(.SyncStages(SyncStages), .IdleLevel(CS_IDLE)) u_cs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (cs_n_i),
    .level_o (cs_level),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  sync_edge_detector #(.SyncStages(SyncStages), .IdleLevel(TC_IDLE)) u_tc_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (transfer_complete_i),
    .level_o (tc_level),
    .rise_o  (byte_evt),
    .fall_o  (tc_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{cs_level, tc_level, tc_fall};

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [DATA_W-1:0]      tx_q, tx_d;
  logic                   write_n_q, write_n_d;
  logic                   busy_q, busy_d;
  logic                   inc_pend_q, inc_pend_d;
  logic                   load_pend_q, load_pend_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      tx_q        <= '0;
      write_n_q   <= 1'b1;
      busy_q      <= 1'b0;
      inc_pend_q  <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tx_q        <= tx_d;
      write_n_q   <= write_n_d;
      busy_q      <= busy_d;
      inc_pend_q  <= inc_pend_d;
      load_pend_q <= load_pend_d;
    end
  end

  // A write advances the address one cycle after its strobe; a read address
  // change is followed one cycle later by a TX load from the bank.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tx_d        = tx_q;
    write_n_d   = 1'b1;
    inc_pend_d  = 1'b0;
    load_pend_d = 1'b0;

    if (inc_pend_q) addr_d = addr_q + AddrWidth'(1);
    if (load_pend_q) tx_d = read_data_i;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (byte_evt) begin
          addr_d = rx_data_i[AddrWidth-1:0];
          if (rx_data_i[READ_FLAG_BIT]) begin
            state_d     = ST_READ;
            load_pend_d = 1'b1;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (byte_evt) begin
          data_d     = rx_data_i;
          write_n_d  = 1'b0;
          inc_pend_d = 1'b1;
        end
      end
      ST_READ: begin
        if (byte_evt) begin
          addr_d      = addr_q + AddrWidth'(1);
          load_pend_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Chip-select release closes the transaction after any same-cycle byte.
    if (cs_rise) state_d = ST_IDLE;

    busy_d = (state_d != ST_IDLE);
  end

  assign address_bus_o = DATA_W'(addr_q);
  assign data_out_o    = data_q;
  assign write_n_o     = write_n_q;
  assign tx_data_o     = tx_q;
  assign busy_o        = busy_q;

endmodule
